viterbi_acs_pmu: RTL
====================

Name: viterbi_acs_pmu

Overview:
Add-compare-select and path-metric unit for the K=3, rate-1/2 hard-decision Viterbi decoder. It sits directly downstream of the branch metric computation stage. Each accepted trellis step, it consumes the 8 two-bit branch metrics, updates the 4 registered path metrics, and emits one survivor decision bit per state plus the current best state to the traceback stage. MSB-clear normalization keeps the metrics bounded.

Parameters:
PM_W, 6, path metric width in bits (min 5); normalization threshold is 2^(PM_W-1)
CNT_W, 16, width of trellis step counter
INIT_PM, 16, reset/start metric for states 1..3 (state 0 starts at 0); must be < 2^(PM_W-1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  frame start; reinitialises path metrics and step counter
bm_valid  in  1  branch metrics valid this cycle; one trellis step per valid cycle
bm_in  in  16  branch metrics; branch into state n from predecessor with LSB d at bits [(2n+d)*2 +: 2]
dec_valid  out  1  registered; high one cycle after each accepted step
dec_bits  out  4  survivor decision per state; bit n = LSB d of the selected predecessor of state n
best_state  out  2  index of minimum new path metric
pm_out  out  4*PM_W  registered path metrics; state n at [n*PM_W +: PM_W]
norm_pulse  out  1  high with dec_valid when normalization was applied on that step
step_cnt  out  CNT_W  number of accepted steps since reset/start; wraps at 2^CNT_W

Behaviour:
- Trellis: state s = {s1,s0}; input bit u gives next state {u,s1}. Predecessors of state n are p_d = {n[0],d}, d in {0,1}.
- ACS per state n: c_d = pm[p_d] + bm(n,d), computed at PM_W+1 bits. Select d=1 only if c_1 < c_0; a tie selects d=0. new[n] = c_sel truncated to PM_W bits. Overflow is impossible under normalization.
- Normalization: if all four new[n] >= 2^(PM_W-1), clear bit PM_W-1 of every new[n] and assert norm_pulse. Otherwise pass new[n] unchanged.
- best_state: argmin over the post-normalization new[] values; the lowest index wins ties.
- Latency: 1 cycle. A bm_valid in cycle t produces dec_valid, dec_bits, best_state, norm_pulse and updated pm_out/step_cnt visible in cycle t+1.
- No backpressure. A step is accepted on every cycle bm_valid=1, including back-to-back cycles. With bm_valid=0, metrics and counter hold, and dec_valid and norm_pulse are 0. dec_bits and best_state hold their last values.
- Reset (rst=1): pm = {state0:0, states1..3:INIT_PM}, step_cnt=0, dec_valid=0, norm_pulse=0, dec_bits=0, best_state=0. rst overrides everything.
- start without bm_valid: metrics are set to init values, step_cnt=0, dec_valid=0.
- start with bm_valid: the ACS step uses the init metrics as previous metrics (not the registered ones). The result is registered, dec_valid=1, and step_cnt=1.
- Reset mid-stream: any in-flight step is discarded. The next cycle's outputs equal the reset values.
- step_cnt wraps from 2^CNT_W-1 to 0 silently.

Test Plan:
- Reset, then one step with bm_in=16'h0000 -> next cycle pm_out = {0,16,0,16} (states 0..3), dec_bits=4'b0000, best_state=0, dec_valid=1, step_cnt=1.
- Reset, then 16 consecutive steps with every branch metric = 2 (bm_in=16'hAAAA):
  - step 1 -> pm = {2,18,2,18};
  - step k (2..15) -> all pm = 2k;
  - step 16 -> all pm = 0 with norm_pulse=1;
  - norm_pulse=0 on all other steps.
- Tie/select check: from reset, bm(0,0)=2, bm(0,1)=0, all others 0 -> state 0 candidates c_0=2, c_1=16 -> dec_bits[0]=0, pm[0]=2. Then repeat with pm[0]=pm[1]=equal metrics -> d=0 chosen on the tie.
- bm_valid gaps: pulse bm_valid on alternate cycles -> dec_valid follows one cycle later, pm_out and step_cnt unchanged in idle cycles.
- start asserted together with bm_valid mid-stream (metrics nonzero) -> result equals the first-step-from-reset result, step_cnt=1. start alone -> pm = {0,16,16,16}, dec_valid=0.
- rst asserted during back-to-back steps -> next cycle dec_valid=0, pm = {0,16,16,16}, step_cnt=0. Step_cnt wrap: set CNT_W=3, run 9 steps -> step_cnt reads 1.

Source files
------------

// File: rtl/viterbi_acs_pmu.sv
// Add-compare-select and path-metric unit for a K=3, rate-1/2 hard-decision Viterbi decoder.
// Latency: 1 cycle from an accepted bm_valid to dec_valid and the updated metrics/counter.
// Backpressure: none; every bm_valid cycle is consumed, including back-to-back cycles.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start                 frame start: reload initial metrics and clear the step counter
//   bm_valid, bm_in       one trellis step of 8 two-bit branch metrics;
//                         bm(n,d) sits at bm_in[(2n+d)*2 +: 2]
//   dec_valid, dec_bits   per-state survivor decisions (bit n = LSB of the chosen predecessor)
//   best_state            index of the smallest new path metric (lowest index on ties)
//   pm_out                registered path metrics; state n at [n*PM_W +: PM_W]
//   norm_pulse            the step just reported was normalized
//   step_cnt              accepted steps since reset/start; wraps silently
module viterbi_acs_pmu #(
  parameter int PM_W    = 6,
  parameter int CNT_W   = 16,
  parameter int INIT_PM = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              bm_valid,
  input  logic [15:0]       bm_in,
  output logic              dec_valid,
  output logic [3:0]        dec_bits,
  output logic [1:0]        best_state,
  output logic [4*PM_W-1:0] pm_out,
  output logic              norm_pulse,
  output logic [CNT_W-1:0]  step_cnt
);

  localparam logic [PM_W-1:0] L_INIT = PM_W'(INIT_PM);

  // Registered state
  logic [PM_W-1:0]  r_pm [4];
  logic             r_dec_valid;
  logic [3:0]       r_dec_bits;
  logic [1:0]       r_best;
  logic             r_norm;
  logic [CNT_W-1:0] r_cnt;

  // ACS datapath
  logic [PM_W-1:0]  w_prev [4];
  logic [PM_W:0]    w_c0   [4];
  logic [PM_W:0]    w_c1   [4];
  logic [3:0]       w_sel;
  logic [PM_W-1:0]  w_new  [4];
  logic [PM_W-1:0]  w_nrm  [4];
  logic             w_norm;
  logic [1:0]       w_best;
  logic [PM_W-1:0]  w_bval;
  logic [CNT_W-1:0] w_cnt_base;

  // A step issued together with start must see the initial metrics, not
  // whatever the previous frame left in the registers.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_prev[n] = '0;
      if (start) begin
        w_prev[n] = (n == 0) ? '0 : L_INIT;
      end else begin
        w_prev[n] = r_pm[n];
      end
    end
  end

  // Predecessors of state n are {n[0],0} and {n[0],1}. Candidates carry one
  // extra bit so the compare is exact before truncation.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_c0[n]  = {1'b0, w_prev[(n % 2) * 2]}
               + {{(PM_W-1){1'b0}}, bm_in[(2*n)*2 +: 2]};
      w_c1[n]  = {1'b0, w_prev[(n % 2) * 2 + 1]}
               + {{(PM_W-1){1'b0}}, bm_in[(2*n+1)*2 +: 2]};
      // Strict less-than: a tie keeps the d=0 predecessor.
      w_sel[n] = (w_c1[n] < w_c0[n]);
      w_new[n] = w_sel[n] ? w_c1[n][PM_W-1:0] : w_c0[n][PM_W-1:0];
    end
  end

  // Subtracting 2^(PM_W-1) from every metric is only safe when all of them
  // have the MSB set; metric differences are bounded, so that always
  // happens before any metric can overflow.
  always_comb begin
    w_norm = 1'b1;
    for (int n = 0; n < 4; n++) begin
      w_norm = w_norm & w_new[n][PM_W-1];
    end
    for (int n = 0; n < 4; n++) begin
      w_nrm[n] = w_new[n];
      if (w_norm) begin
        w_nrm[n][PM_W-1] = 1'b0;
      end
    end
  end

  // Argmin over normalized metrics; scanning upward with strict less-than
  // lets the lowest index win ties.
  always_comb begin
    w_best = 2'd0;
    w_bval = w_nrm[0];
    for (int n = 1; n < 4; n++) begin
      if (w_nrm[n] < w_bval) begin
        w_bval = w_nrm[n];
        w_best = 2'(n);
      end
    end
  end

  assign w_cnt_base = start ? '0 : r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pm[0]     <= '0;
      r_pm[1]     <= L_INIT;
      r_pm[2]     <= L_INIT;
      r_pm[3]     <= L_INIT;
      r_dec_valid <= 1'b0;
      r_dec_bits  <= '0;
      r_best      <= '0;
      r_norm      <= 1'b0;
      r_cnt       <= '0;
    end else if (bm_valid) begin
      for (int n = 0; n < 4; n++) begin
        r_pm[n] <= w_nrm[n];
      end
      r_dec_valid <= 1'b1;
      r_dec_bits  <= w_sel;
      r_best      <= w_best;
      r_norm      <= w_norm;
      r_cnt       <= w_cnt_base + CNT_W'(1);
    end else begin
      // Idle: decisions and best state hold, strobes drop.
      r_dec_valid <= 1'b0;
      r_norm      <= 1'b0;
      if (start) begin
        r_pm[0] <= '0;
        r_pm[1] <= L_INIT;
        r_pm[2] <= L_INIT;
        r_pm[3] <= L_INIT;
        r_cnt   <= '0;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_pm_out
      assign pm_out[g*PM_W +: PM_W] = r_pm[g];
    end
  endgenerate

  assign dec_valid  = r_dec_valid;
  assign dec_bits   = r_dec_bits;
  assign best_state = r_best;
  assign norm_pulse = r_norm;
  assign step_cnt   = r_cnt;

endmodule
